// File: rtl/led_key_history_pkg.sv
// Shared encodings for the LED key history display.
//   mode_e   : selection of what the red LEDs show
//   gstate_e : green-LED key activity FSM states
package led_key_history_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE = 2'd0,
        MODE_LAST = 2'd1,
        MODE_HIST = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        G_IDLE    = 2'd0,
        G_ACTIVE  = 2'd1,
        G_STRETCH = 2'd2
    } gstate_e;

endpackage

// File: rtl/led_key_history_buf.sv
// DEPTH x KEY_W key-code history ring with write pointer and saturating fill count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data at the current write pointer (one capture)
//   wr_data    : key code to capture
//   rd_age     : age offset of the entry to read (0 = newest)
//   rd_data    : combinational read of the entry rd_age back from newest
//   count      : number of valid entries, saturates at DEPTH
module led_key_history_buf
    import led_key_history_pkg::*;
#(
    parameter int KEY_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [KEY_W-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_age,
    output logic [KEY_W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [KEY_W-1:0] hist_r [DEPTH];
    logic [IDX_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [IDX_W-1:0] rd_ptr_s;

    // Ring storage, pointer (wraps naturally since DEPTH is a power of 2) and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (wr_en) begin
            hist_r[wr_ptr_r] <= wr_data;
            wr_ptr_r         <= wr_ptr_r + IDX_W'(1);
            if (count_r != CNT_W'(DEPTH)) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end
    end

    // Newest entry sits one slot behind the write pointer.
    always_comb begin
        rd_ptr_s = wr_ptr_r - IDX_W'(1) - rd_age;
        rd_data  = hist_r[rd_ptr_s];
        count    = count_r;
    end

endmodule

// File: rtl/led_key_history.sv
// LED key history display: captures each new key press into a history ring and shows the
// live, last or browsed key code on the red LEDs; green LEDs show key activity with a
// release pulse-stretch.
// Build option: define LED_BLINK_EN to blink the green LEDs during the stretch window
// (BLINK_DIV cycles per half-period); otherwise they stay steady all zeros while stretching.
// Ports:
//   clock27     : system clock
//   reset_n     : asynchronous active-low reset
//   key_pressed : high while a key is held
//   key_data    : current key code
//   mode        : 0 LIVE, 1 LAST, 2 HISTORY, 3 OFF
//   sel_step    : one-cycle pulse, advance the browsed history index
//   led_r       : shown code in the top KEY_W bits, shown index in the low bits
//   led_g       : key activity status
module led_key_history
    import led_key_history_pkg::*;
#(
    parameter int KEY_W   = 8,
    parameter int R_LEDS  = 10,
    parameter int G_LEDS  = 8,
    parameter int DEPTH   = 4,
    parameter int STRETCH = 27
`ifdef LED_BLINK_EN
    , parameter int BLINK_DIV = 4
`endif
) (
    input  logic              clock27,
    input  logic              reset_n,
    input  logic              key_pressed,
    input  logic [KEY_W-1:0]  key_data,
    input  logic [1:0]        mode,
    input  logic              sel_step,
    output logic [R_LEDS-1:0] led_r,
    output logic [G_LEDS-1:0] led_g
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int SC_W  = $clog2(STRETCH) + 1;
    localparam int IW    = R_LEDS - KEY_W;
    localparam logic [R_LEDS-1:0] IDX_MASK = (R_LEDS'(1) << IW) - R_LEDS'(1);

    logic              key_prev_r;
    logic              press_s;
    logic [1:0]        mode_prev_r;
    logic [IDX_W-1:0]  rd_idx_r;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  rd_age_s;
    logic [KEY_W-1:0]  buf_data_s;
    logic [CNT_W-1:0]  buf_count_s;
    logic [KEY_W-1:0]  code_s;
    logic [IDX_W-1:0]  show_idx_s;
    logic [R_LEDS-1:0] led_r_s;
    gstate_e           state_r;
    gstate_e           state_s;
    logic [SC_W-1:0]   stretch_cnt_r;
    logic [G_LEDS-1:0] led_g_s;

    assign press_s = key_pressed & ~key_prev_r;

    led_key_history_buf #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clock27),
        .rst_n   (reset_n),
        .wr_en   (press_s),
        .wr_data (key_data),
        .rd_age  (rd_age_s),
        .rd_data (buf_data_s),
        .count   (buf_count_s)
    );

    // Edge-detect history, mode-change history and browsed index.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            key_prev_r  <= 1'b0;
            mode_prev_r <= 2'd0;
            rd_idx_r    <= '0;
        end else begin
            key_prev_r  <= key_pressed;
            mode_prev_r <= mode;
            rd_idx_r    <= rd_idx_s;
        end
    end

    // Next browse index: a press or mode change wins, then sel_step wraps after count-1.
    always_comb begin
        rd_idx_s = rd_idx_r;
        if (press_s || (mode != mode_prev_r)) begin
            rd_idx_s = '0;
        end else if (sel_step && (mode == MODE_HIST)) begin
            if (buf_count_s == CNT_W'(0)) begin
                rd_idx_s = '0;
            end else if (CNT_W'(rd_idx_r) == (buf_count_s - CNT_W'(1))) begin
                rd_idx_s = '0;
            end else begin
                rd_idx_s = rd_idx_r + IDX_W'(1);
            end
        end else begin
            rd_idx_s = rd_idx_r;
        end
    end

    // Red LED content. A press this cycle bypasses the ring so the new code shows at once;
    // the index is then 0, so the bypassed code is always the one being read.
    always_comb begin
        rd_age_s   = (mode == MODE_LAST) ? IDX_W'(0) : rd_idx_s;
        code_s     = '0;
        show_idx_s = '0;
        case (mode)
            MODE_LIVE: begin
                code_s = key_data;
            end
            MODE_LAST: begin
                if (press_s) begin
                    code_s = key_data;
                end else if (buf_count_s == CNT_W'(0)) begin
                    code_s = '0;
                end else begin
                    code_s = buf_data_s;
                end
            end
            MODE_HIST: begin
                show_idx_s = rd_idx_s;
                if (press_s) begin
                    code_s = key_data;
                end else if (buf_count_s == CNT_W'(0)) begin
                    code_s = '0;
                end else begin
                    code_s = buf_data_s;
                end
            end
            default: begin
                code_s = '0;
            end
        endcase
        led_r_s = (R_LEDS'(code_s) << IW) | (R_LEDS'(show_idx_s) & IDX_MASK);
    end

    // Green FSM state register and stretch counter (holds at 0).
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= G_IDLE;
            stretch_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == G_ACTIVE) && (state_s == G_STRETCH)) begin
                stretch_cnt_r <= SC_W'(STRETCH - 1);
            end else if ((state_r == G_STRETCH) && (stretch_cnt_r != SC_W'(0))) begin
                stretch_cnt_r <= stretch_cnt_r - SC_W'(1);
            end else begin
                stretch_cnt_r <= stretch_cnt_r;
            end
        end
    end

    // Green FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            G_IDLE:    state_s = key_pressed ? G_ACTIVE : G_IDLE;
            G_ACTIVE:  state_s = key_pressed ? G_ACTIVE : G_STRETCH;
            G_STRETCH: begin
                if (key_pressed) begin
                    state_s = G_ACTIVE;
                end else if (stretch_cnt_r == SC_W'(0)) begin
                    state_s = G_IDLE;
                end else begin
                    state_s = G_STRETCH;
                end
            end
            default:   state_s = G_IDLE;
        endcase
    end

`ifdef LED_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV) + 1;
    logic [BW-1:0] blink_cnt_r;
    logic [BW-1:0] blink_cnt_s;
    logic          blink_ph_r;
    logic          blink_ph_s;

    // Blink phase: restarts dark on every stretch entry, flips every BLINK_DIV cycles.
    always_comb begin
        blink_cnt_s = blink_cnt_r;
        blink_ph_s  = blink_ph_r;
        if ((state_s == G_STRETCH) && (state_r != G_STRETCH)) begin
            blink_cnt_s = '0;
            blink_ph_s  = 1'b0;
        end else if (state_s == G_STRETCH) begin
            if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
                blink_cnt_s = '0;
                blink_ph_s  = ~blink_ph_r;
            end else begin
                blink_cnt_s = blink_cnt_r + BW'(1);
                blink_ph_s  = blink_ph_r;
            end
        end else begin
            blink_cnt_s = blink_cnt_r;
            blink_ph_s  = blink_ph_r;
        end
    end

    // Blink counter registers.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= '0;
            blink_ph_r  <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_s;
            blink_ph_r  <= blink_ph_s;
        end
    end
`endif

    // Green FSM output decode from the next state, so the register shows it the same edge.
    always_comb begin
        led_g_s = '1;
        case (state_s)
            G_IDLE:    led_g_s = '1;
            G_ACTIVE:  led_g_s = '0;
`ifdef LED_BLINK_EN
            G_STRETCH: led_g_s = blink_ph_s ? '1 : '0;
`else
            G_STRETCH: led_g_s = '0;
`endif
            default:   led_g_s = '1;
        endcase
    end

    // Output registers.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            led_r <= '0;
            led_g <= '1;
        end else begin
            led_r <= led_r_s;
            led_g <= led_g_s;
        end
    end

endmodule

// File: tb/tb_led_key_history.sv
module tb_led_key_history;

    localparam logic [1:0] LIVE = 2'd0;
    localparam logic [1:0] LAST = 2'd1;
    localparam logic [1:0] HIST = 2'd2;
    localparam logic [1:0] OFF  = 2'd3;

    logic       clock27;
    logic       reset_n;
    logic       key_pressed;
    logic [7:0] key_data;
    logic [1:0] mode;
    logic       sel_step;
    logic [9:0] led_r;
    logic [7:0] led_g;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [9:0] r;
        logic [7:0] g;
    } exp_t;

    exp_t sb[$];

    led_key_history dut (
        .clock27     (clock27),
        .reset_n     (reset_n),
        .key_pressed (key_pressed),
        .key_data    (key_data),
        .mode        (mode),
        .sel_step    (sel_step),
        .led_r       (led_r),
        .led_g       (led_g)
    );

    initial clock27 = 1'b0;
    always #5 clock27 = ~clock27;

    // Green level expected k cycles after the release edge (k=0 is the release edge).
    function automatic logic [7:0] stretch_g(input int k);
`ifdef LED_BLINK_EN
        return (((k / 4) % 2) == 1) ? 8'hFF : 8'h00;
`else
        return (k >= 0) ? 8'h00 : 8'hFF;
`endif
    endfunction

    task automatic push(input string tag, input logic [9:0] r, input logic [7:0] g);
        exp_t e;
        e.tag = tag;
        e.r   = r;
        e.g   = g;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            total++;
            assert (led_r === e.r) else begin
                bad++;
                $error("FAIL %s led_r observed=%h expected=%h", e.tag, led_r, e.r);
            end
            total++;
            assert (led_g === e.g) else begin
                bad++;
                $error("FAIL %s led_g observed=%h expected=%h", e.tag, led_g, e.g);
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input logic kp, input logic [7:0] kd, input logic [1:0] md,
                       input logic ss, input logic chk, input logic [9:0] er,
                       input logic [7:0] eg, input string tag);
        @(negedge clock27);
        key_pressed = kp;
        key_data    = kd;
        mode        = md;
        sel_step    = ss;
        if (chk) push(tag, er, eg);
        @(posedge clock27);
        #1;
        if (chk) check_pop();
    endtask

    initial begin
        reset_n     = 1'b0;
        key_pressed = 1'b0;
        key_data    = 8'h00;
        mode        = LIVE;
        sel_step    = 1'b0;

        // Reset values while held.
        #12;
        push("reset_hold", 10'h000, 8'hFF);
        check_pop();
        @(negedge clock27);
        reset_n = 1'b1;
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'hFF, "reset_release");

        // LIVE press and hold.
        cyc(1'b1, 8'hA5, LIVE, 1'b0, 1'b1, 10'b1010010100, 8'h00, "live_press");
        cyc(1'b1, 8'hA5, LIVE, 1'b0, 1'b1, 10'h294, 8'h00, "live_hold");

        // Release and stretch window.
        cyc(1'b0, 8'hA5, LIVE, 1'b0, 1'b1, 10'h294, stretch_g(0), "stretch_m");
        for (int k = 1; k <= 26; k++) begin
            cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, stretch_g(k), "stretch_hold");
        end
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'hFF, "stretch_end");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'hFF, "idle_after");

        // LAST shows the only captured code.
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h294, 8'hFF, "last_a5");

        // Fill history: 11..44 with releases, 55 pressed and held.
        cyc(1'b1, 8'h11, LAST, 1'b0, 1'b1, 10'h044, 8'h00, "last_11");
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h044, 8'h00, "last_11_rel");
        cyc(1'b1, 8'h22, LAST, 1'b0, 1'b1, 10'h088, 8'h00, "last_22");
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h088, 8'h00, "last_22_rel");
        cyc(1'b1, 8'h33, LAST, 1'b0, 1'b1, 10'h0CC, 8'h00, "last_33");
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h0CC, 8'h00, "last_33_rel");
        cyc(1'b1, 8'h44, LAST, 1'b0, 1'b1, 10'h110, 8'h00, "last_44");
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h110, 8'h00, "last_44_rel");
        cyc(1'b1, 8'h55, LAST, 1'b0, 1'b1, 10'h154, 8'h00, "last_55");

        // Browse history with the key held.
        cyc(1'b1, 8'h55, HIST, 1'b0, 1'b1, 10'h154, 8'h00, "hist_idx0");
        cyc(1'b1, 8'h55, HIST, 1'b1, 1'b1, 10'h111, 8'h00, "hist_idx1");
        cyc(1'b1, 8'h55, HIST, 1'b1, 1'b1, 10'h0CE, 8'h00, "hist_idx2");
        cyc(1'b1, 8'h55, HIST, 1'b1, 1'b1, 10'h08B, 8'h00, "hist_idx3");
        cyc(1'b1, 8'h55, HIST, 1'b1, 1'b1, 10'h154, 8'h00, "hist_wrap");
        cyc(1'b1, 8'h55, HIST, 1'b0, 1'b1, 10'h154, 8'h00, "hist_nostep");

        // Collision of sel_step with a new press, then held key re-captures nothing.
        cyc(1'b0, 8'h00, HIST, 1'b1, 1'b1, 10'h111, 8'h00, "hist_rel_step");
        cyc(1'b1, 8'h66, HIST, 1'b1, 1'b1, 10'h198, 8'h00, "collide");
        cyc(1'b1, 8'h66, HIST, 1'b1, 1'b1, 10'h155, 8'h00, "held_age1");
        cyc(1'b1, 8'h66, HIST, 1'b1, 1'b1, 10'h112, 8'h00, "held_age2");
        cyc(1'b0, 8'h00, HIST, 1'b0, 1'b1, 10'h112, 8'h00, "hist_rel");

        // OFF mode, then let the stretch expire.
        cyc(1'b0, 8'h00, OFF, 1'b0, 1'b1, 10'h000, 8'h00, "off_mode");
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 8'h00, OFF, 1'b0, 1'b0, 10'h000, 8'h00, "");
        end
        cyc(1'b0, 8'h00, OFF, 1'b0, 1'b1, 10'h000, 8'hFF, "off_idle");

        // Asynchronous reset in the middle of a stretch.
        cyc(1'b1, 8'h77, LIVE, 1'b0, 1'b0, 10'h000, 8'h00, "");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b0, 10'h000, 8'h00, "");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'h00, "pre_reset_stretch");
        @(negedge clock27);
        #2;
        reset_n = 1'b0;
        push("async_reset", 10'h000, 8'hFF);
        #1;
        check_pop();
        @(negedge clock27);
        reset_n = 1'b1;

        // Empty history after reset.
        cyc(1'b0, 8'h00, LAST, 1'b0, 1'b1, 10'h000, 8'hFF, "last_empty");
        cyc(1'b0, 8'h00, HIST, 1'b1, 1'b1, 10'h000, 8'hFF, "hist_empty0");
        cyc(1'b0, 8'h00, HIST, 1'b1, 1'b1, 10'h000, 8'hFF, "hist_empty_step");

`ifdef LED_BLINK_EN
        // Blink pattern on release, then re-press mid-blink.
        cyc(1'b1, 8'h07, LIVE, 1'b0, 1'b1, 10'h01C, 8'h00, "blink_press");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'h00, "blink_m0");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'h00, "blink_m1");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'h00, "blink_m2");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'h00, "blink_m3");
        cyc(1'b0, 8'h00, LIVE, 1'b0, 1'b1, 10'h000, 8'hFF, "blink_m4");
        cyc(1'b1, 8'h07, LIVE, 1'b0, 1'b1, 10'h01C, 8'h00, "blink_repress");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
